// File: rtl/dht11_poll_ctrl.sv
// -----------------------------------------------------------------------------
// dht11_poll_ctrl
//
// Sequencing controller for the DHT11 single-wire reader. Accepts host read
// requests or polls autonomously. Enforces the sensor's minimum inter-read
// gap, strobes the reader's start input, supervises done with a timeout,
// retries failed reads and latches validated humidity/temperature bytes.
//
// Build option:
//   DHT_POLL_RETRY_EN  defined     -> failed attempts are retried up to
//                                     MAX_RETRY extra times before fail.
//                      undefined   -> the first failed attempt pulses fail.
//
// Ports:
//   clk         system clock (same clock as the reader)
//   rst         synchronous active-high reset
//   req         host read request, single-cycle pulse
//   auto_en     level, keep reading back-to-back while high
//   sens_start  to reader start
//   sens_done   from reader done (level, several cycles wide)
//   sens_error  from reader error, sampled on the done rising edge
//   sens_data   from reader data, sampled on the done rising edge
//   busy        high whenever the controller is not idle
//   data_valid  one-cycle pulse when hum/temp are updated
//   fail        one-cycle pulse when all attempts are exhausted
//   hum, temp   integral humidity / temperature bytes of the last good read
//   err_cnt     failed attempts, saturating at 255
// -----------------------------------------------------------------------------
module dht11_poll_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int MIN_GAP_MS = 2000,
  parameter int TIMEOUT_MS = 100,
  parameter int START_HOLD = 128,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        auto_en,
  output logic        sens_start,
  input  logic        sens_done,
  input  logic        sens_error,
  input  logic [39:0] sens_data,
  output logic        busy,
  output logic        data_valid,
  output logic        fail,
  output logic [7:0]  hum,
  output logic [7:0]  temp,
  output logic [7:0]  err_cnt
);

  // The gap and the timeout never run at the same time, so one ms counter
  // serves both; it saturates at the larger of the two limits.
  localparam int MS_MAX = (MIN_GAP_MS > TIMEOUT_MS) ? MIN_GAP_MS : TIMEOUT_MS;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   MS_TOP    = MS_W'(MS_MAX);
  localparam logic [MS_W-1:0]   GAP_MS    = MS_W'(MIN_GAP_MS);
  localparam logic [MS_W-1:0]   TO_MS     = MS_W'(TIMEOUT_MS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_TRIG = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_EVAL = 3'd4;

  if (TICK_DIV < 1 || START_HOLD < 1 || TIMEOUT_MS < 1 ||
      MIN_GAP_MS < 0 || MAX_RETRY < 0) begin : g_bad_params
    $error("dht11_poll_ctrl: illegal parameter value");
  end

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              tmr_clr;
  logic [PRE_W-1:0]  pre_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              done_q;
  logic              done_edge;
  logic [7:0]        cap_hum;
  logic [7:0]        cap_temp;
  logic              cap_err;
  logic              eval_timeout;
  logic              eval_err;
  logic              pending;
  logic              unused_data_bits;

`ifdef DHT_POLL_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_TOP = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_ok;
  assign retry_ok = (retry_cnt != RETRY_TOP);
`endif

  // Only the integral humidity and temperature bytes are kept.
  assign unused_data_bits = ^{sens_data[31:24], sens_data[15:0]};

  // A timeout is reported as an error exactly like a bad checksum.
  assign eval_err = eval_timeout | cap_err;

  // rst also gates the strobe so the reader sees it drop right away.
  assign sens_start = (state == S_TRIG) && !rst;
  assign busy       = (state != S_IDLE);

  // Next-state decode. tmr_clr marks the two points where the shared ms
  // timer restarts: entering TRIG (timeout) and leaving EVAL (gap).
  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    case (state)
      S_IDLE: if (req || pending || auto_en) state_nxt = S_GAP;
      S_GAP: begin
        if (ms_cnt >= GAP_MS) begin
          state_nxt = S_TRIG;
          tmr_clr   = 1'b1;
        end
      end
      S_TRIG: if (hold_cnt == HOLD_LAST) state_nxt = S_WAIT;
      S_WAIT: if (done_edge || (ms_cnt == TO_MS)) state_nxt = S_EVAL;
      S_EVAL: begin
        tmr_clr   = 1'b1;
        state_nxt = S_IDLE;
`ifdef DHT_POLL_RETRY_EN
        if (eval_err && retry_ok) state_nxt = S_GAP;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Reset starts the timer from zero, so the first read still honours the gap.
  always_ff @(posedge clk) begin
    if (rst || tmr_clr) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      if (ms_cnt != MS_TOP) ms_cnt <= ms_cnt + MS_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_TRIG) hold_cnt <= '0;
    else                        hold_cnt <= hold_cnt + HOLD_W'(1);
  end

  // Registered edge detect on done; the payload is captured on the raw edge
  // so it is already stable when WAIT acts on the registered edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q       <= 1'b0;
      done_edge    <= 1'b0;
      cap_hum      <= '0;
      cap_temp     <= '0;
      cap_err      <= 1'b0;
      eval_timeout <= 1'b0;
    end else begin
      done_q    <= sens_done;
      done_edge <= sens_done & ~done_q;
      if (sens_done && !done_q) begin
        cap_hum  <= sens_data[39:32];
        cap_temp <= sens_data[23:16];
        cap_err  <= sens_error;
      end
      if (state == S_WAIT && state_nxt == S_EVAL) eval_timeout <= ~done_edge;
    end
  end

  // One-deep request memory; the IDLE visit that consumes it also clears it.
  always_ff @(posedge clk) begin
    if (rst)                  pending <= 1'b0;
    else if (state == S_IDLE) pending <= 1'b0;
    else if (req)             pending <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
      fail       <= 1'b0;
      hum        <= '0;
      temp       <= '0;
      err_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      fail       <= 1'b0;
      if (state == S_EVAL) begin
        if (!eval_err) begin
          hum        <= cap_hum;
          temp       <= cap_temp;
          data_valid <= 1'b1;
        end else begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef DHT_POLL_RETRY_EN
          if (!retry_ok) fail <= 1'b1;
`else
          fail <= 1'b1;
`endif
        end
      end
    end
  end

`ifdef DHT_POLL_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (state == S_EVAL) begin
      if (eval_err && retry_ok) retry_cnt <= retry_cnt + RETRY_W'(1);
      else                      retry_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dht11_poll_ctrl
//
// Drives dht11_poll_ctrl with a behavioural DHT11 reader model. Every read
// the bench expects is pushed into a scoreboard queue; a monitor pops and
// compares whenever the controller pulses data_valid or fail.
// Honours DHT_POLL_RETRY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dht11_poll_ctrl;

  localparam int TICK_DIV   = 10;
  localparam int MIN_GAP_MS = 3;
  localparam int TIMEOUT_MS = 5;
  localparam int START_HOLD = 4;
  localparam int MAX_RETRY  = 2;
  localparam int GAP_CYC    = TICK_DIV * MIN_GAP_MS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        auto_en = 1'b0;
  logic        sens_start;
  logic        sens_done;
  logic        sens_error;
  logic [39:0] sens_data;
  logic        busy;
  logic        data_valid;
  logic        fail;
  logic [7:0]  hum;
  logic [7:0]  temp;
  logic [7:0]  err_cnt;

  dht11_poll_ctrl #(
    .TICK_DIV(TICK_DIV), .MIN_GAP_MS(MIN_GAP_MS), .TIMEOUT_MS(TIMEOUT_MS),
    .START_HOLD(START_HOLD), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .auto_en(auto_en),
    .sens_start(sens_start), .sens_done(sens_done), .sens_error(sens_error),
    .sens_data(sens_data), .busy(busy), .data_valid(data_valid), .fail(fail),
    .hum(hum), .temp(temp), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [39:0] data;
  } resp_t;

  typedef struct {
    bit         is_fail;
    logic [7:0] hum;
    logic [7:0] temp;
    logic [7:0] err;
  } exp_t;

  resp_t resp_q[$];
  exp_t  exp_q[$];

  int checks    = 0;
  int passed    = 0;
  int starts    = 0;
  int last_rise = -1;
  int done_rise = 0;
  int dv_seen   = 0;
  bit abort_hold = 1'b0;

  logic [7:0] exp_hum  = 8'h00;
  logic [7:0] exp_temp = 8'h00;
  logic [7:0] exp_err  = 8'h00;

  task automatic checkOutput(input string name, input bit ok,
                             input longint act, input longint need);
    checks++;
    if (ok) passed++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                  name, act, act, need, need);
  endtask

  task automatic applyStimulus();
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && busy == 1'b0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_complete"}, n < budget, n, budget);
  endtask

  task automatic expectRead(input bit is_fail);
    exp_q.push_back('{is_fail, exp_hum, exp_temp, exp_err});
  endtask

  // Reader model: measures each start strobe, then answers with the next
  // queued response five cycles after start falls, or stays silent if none.
  initial begin : sensor_model
    resp_t r;
    int    len;
    sens_done  = 1'b0;
    sens_error = 1'b0;
    sens_data  = '0;
    forever begin
      @(posedge sens_start); #1;
      starts++;
      if (last_rise >= 0 && !abort_hold)
        checkOutput("start_spacing", (cyc - last_rise) >= GAP_CYC,
                    cyc - last_rise, GAP_CYC);
      last_rise = cyc;
      len = 0;
      while (sens_start === 1'b1 && len < 100) begin
        @(posedge clk); #1;
        len++;
      end
      if (!abort_hold)
        checkOutput("start_hold", len == START_HOLD, len, START_HOLD);
      if (resp_q.size() > 0) begin
        r = resp_q.pop_front();
        repeat (5) @(posedge clk);
        #1;
        sens_data  = r.data;
        sens_error = r.err;
        sens_done  = 1'b1;
        done_rise  = cyc;
        repeat (6) @(posedge clk);
        #1;
        sens_done  = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (data_valid || fail)) begin
      if (data_valid) dv_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", 1'b0, longint'({data_valid, fail}), 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput(e.is_fail ? "fail_event" : "valid_event",
                    fail == e.is_fail && data_valid == !e.is_fail &&
                    hum == e.hum && temp == e.temp && err_cnt == e.err,
                    longint'({fail, data_valid, hum, temp, err_cnt}),
                    longint'({e.is_fail, !e.is_fail, e.hum, e.temp, e.err}));
        if (data_valid)
          checkOutput("valid_latency", (cyc - done_rise) == 3, cyc - done_rise, 3);
      end
    end
  end

  initial begin : main
    int rel;
    int s0;
    int d0;
    int n;

    $display("[TB] reset");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sens_start", sens_start == 1'b0, sens_start, 0);
    checkOutput("rst_busy", busy == 1'b0, busy, 0);
    checkOutput("rst_data_valid", data_valid == 1'b0, data_valid, 0);
    checkOutput("rst_fail", fail == 1'b0, fail, 0);
    checkOutput("rst_hum", hum == 8'h00, hum, 0);
    checkOutput("rst_temp", temp == 8'h00, temp, 0);
    checkOutput("rst_err_cnt", err_cnt == 8'h00, err_cnt, 0);
    rst = 1'b0;
    rel = cyc;

    $display("[TB] reset gap and good read");
    s0 = starts;
    resp_q.push_back('{1'b0, 40'h2D00170044});
    exp_hum = 8'h2D; exp_temp = 8'h17;
    expectRead(1'b0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus();
    waitIdle("good_read", 400);
    checkOutput("reset_gap", (last_rise - rel) >= GAP_CYC, last_rise - rel, GAP_CYC);
    checkOutput("good_attempts", starts == s0 + 1, starts - s0, 1);
    checkOutput("good_hum", hum == 8'h2D, hum, 8'h2D);
    checkOutput("good_temp", temp == 8'h17, temp, 8'h17);

    $display("[TB] checksum error then good read");
    s0 = starts;
    resp_q.delete();
    resp_q.push_back('{1'b1, 40'hEE00EE0000});
    resp_q.push_back('{1'b0, 40'h3C00190011});
    exp_err = exp_err + 8'd1;
`ifdef DHT_POLL_RETRY_EN
    exp_hum = 8'h3C; exp_temp = 8'h19;
    expectRead(1'b0);
`else
    expectRead(1'b1);
`endif
    applyStimulus();
    waitIdle("checksum_retry", 600);
`ifdef DHT_POLL_RETRY_EN
    checkOutput("retry_attempts", starts == s0 + 2, starts - s0, 2);
`else
    checkOutput("retry_attempts", starts == s0 + 1, starts - s0, 1);
`endif
    checkOutput("retry_err_cnt", err_cnt == exp_err, err_cnt, exp_err);

    $display("[TB] timeout exhaustion");
    s0 = starts;
    resp_q.delete();
`ifdef DHT_POLL_RETRY_EN
    exp_err = exp_err + 8'd3;
`else
    exp_err = exp_err + 8'd1;
`endif
    expectRead(1'b1);
    applyStimulus();
    waitIdle("timeout", 1500);
`ifdef DHT_POLL_RETRY_EN
    checkOutput("timeout_attempts", starts == s0 + 3, starts - s0, 3);
`else
    checkOutput("timeout_attempts", starts == s0 + 1, starts - s0, 1);
`endif
    checkOutput("timeout_hum_kept", hum == exp_hum, hum, exp_hum);

    $display("[TB] pending request");
    s0 = starts;
    resp_q.push_back('{1'b0, 40'h41001A0000});
    resp_q.push_back('{1'b0, 40'h3700150000});
    exp_hum = 8'h41; exp_temp = 8'h1A;
    expectRead(1'b0);
    exp_hum = 8'h37; exp_temp = 8'h15;
    expectRead(1'b0);
    applyStimulus();
    n = 0;
    while (!(starts == s0 + 1 && sens_start == 1'b0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("pending_reach_wait", n < 200, n, 200);
    applyStimulus();
    @(posedge clk); #1;
    applyStimulus();
    waitIdle("pending", 600);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("pending_reads", starts == s0 + 2, starts - s0, 2);
    checkOutput("pending_idle", busy == 1'b0, busy, 0);

    $display("[TB] auto mode");
    s0 = starts;
    d0 = dv_seen;
    resp_q.push_back('{1'b0, 40'h2800140000});
    resp_q.push_back('{1'b0, 40'h2900150000});
    resp_q.push_back('{1'b0, 40'h2A00160000});
    exp_hum = 8'h28; exp_temp = 8'h14; expectRead(1'b0);
    exp_hum = 8'h29; exp_temp = 8'h15; expectRead(1'b0);
    exp_hum = 8'h2A; exp_temp = 8'h16; expectRead(1'b0);
    auto_en = 1'b1;
    n = 0;
    while (dv_seen < d0 + 3 && n < 800) begin
      @(negedge clk); #1;
      n++;
    end
    auto_en = 1'b0;
    checkOutput("auto_reads", dv_seen == d0 + 3, dv_seen - d0, 3);
    waitIdle("auto", 400);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("auto_stopped", starts == s0 + 3 && busy == 1'b0,
                starts - s0, 3);

    $display("[TB] reset during start strobe");
    applyStimulus();
    n = 0;
    while (sens_start == 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("trig_reached", n < 200, n, 200);
    abort_hold = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_sens_start", sens_start == 1'b0, sens_start, 0);
    checkOutput("midrst_busy", busy == 1'b0, busy, 0);
    checkOutput("midrst_data_valid", data_valid == 1'b0, data_valid, 0);
    checkOutput("midrst_fail", fail == 1'b0, fail, 0);
    checkOutput("midrst_hum", hum == 8'h00, hum, 0);
    checkOutput("midrst_temp", temp == 8'h00, temp, 0);
    checkOutput("midrst_err_cnt", err_cnt == 8'h00, err_cnt, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("post_rst_idle", busy == 1'b0 && sens_start == 1'b0,
                longint'({busy, sens_start}), 0);
    checkOutput("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
